// File: rtl/decode_pkg.sv
// Decode-stage shared types: instruction field positions, opcode classes, ID/EX payload.
// Pure definitions: no latency, no flow control.
package decode_pkg;

  localparam int OPC_W  = 5;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 18;
  localparam int VEC_W  = 64;
  localparam int IMM_W  = 15;

  localparam int OPC_LSB = 27;
  localparam int RD_LSB  = 23;
  localparam int RS1_LSB = 19;
  localparam int RS2_LSB = 15;
  localparam int IMM_LSB = 0;

  localparam logic [OPC_W-1:0] OP_NOP    = '0;
  localparam logic [3:0]       OP_STORE  = 4'hE;
  localparam logic [3:0]       OP_BRANCH = 4'hF;

  // STORE and BRANCH classes ignore the vector/scalar bit.
  function automatic logic writes_dest(input logic [OPC_W-1:0] opcode);
    return (opcode != OP_NOP) && (opcode[3:0] != OP_STORE) && (opcode[3:0] != OP_BRANCH);
  endfunction

  typedef struct packed {
    logic [OPC_W-1:0]  opcode;
    logic [ADDR_W-1:0] rd;
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic              is_vector;
    logic              writes_rd;
    logic [DATA_W-1:0] reg1_scalar;
    logic [DATA_W-1:0] reg2_scalar;
    logic [VEC_W-1:0]  reg1_vector;
    logic [VEC_W-1:0]  reg2_vector;
    logic [DATA_W-1:0] immediate;
  } decoded_t;

endpackage

// File: rtl/decode_stage_pipelined_register_file_bypass.sv
// Two-read one-write register file; reads are combinational with same-cycle write-back bypass.
// Write lands on the clock edge; no backpressure.
module register_file_bypass #(
  parameter int WIDTH      = 18,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [ADDR_WIDTH-1:0] raddr1,
  input  logic [ADDR_WIDTH-1:0] raddr2,
  output logic [WIDTH-1:0]      rdata1,
  output logic [WIDTH-1:0]      rdata2
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we && (int'(waddr) < DEPTH)) mem_d[waddr] = wdata;
  end

  always_comb begin
    rdata1 = '0;
    if (we && (waddr == raddr1))   rdata1 = wdata;
    else if (int'(raddr1) < DEPTH) rdata1 = mem_q[raddr1];
  end

  always_comb begin
    rdata2 = '0;
    if (we && (waddr == raddr2))   rdata2 = wdata;
    else if (int'(raddr2) < DEPTH) rdata2 = mem_q[raddr2];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/decode_stage_pipelined.sv
// Decode stage: field split, scalar/vector operand read with bypass, RAW scoreboard, ID/EX register.
// One-cycle latency; in_ready drops on hazard, flush, or a full ID/EX held by out_ready=0.
module decode_stage_pipelined
  import decode_pkg::*;
#(
  parameter int DATA_WIDTH        = DATA_W,
  parameter int ELEM_WIDTH        = 8,
  parameter int VECTOR_SIZE       = 8,
  parameter int SCALAR_REGNUM     = 16,
  parameter int VECTOR_REGNUM     = 16,
  parameter int ADDRESS_WIDTH     = ADDR_W,
  parameter int OPCODE_WIDTH      = OPC_W,
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int IMM_WIDTH         = IMM_W
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [INSTRUCTION_WIDTH-1:0]      instruction,
  input  logic                              flush,
  input  logic                              wb_scalar_en,
  input  logic                              wb_vector_en,
  input  logic [ADDRESS_WIDTH-1:0]          wb_address,
  input  logic [DATA_WIDTH-1:0]             wb_scalar_data,
  input  logic [VECTOR_SIZE*ELEM_WIDTH-1:0] wb_vector_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [OPCODE_WIDTH-1:0]           out_opcode,
  output logic [ADDRESS_WIDTH-1:0]          out_rd,
  output logic [ADDRESS_WIDTH-1:0]          out_rs1,
  output logic [ADDRESS_WIDTH-1:0]          out_rs2,
  output logic                              out_is_vector,
  output logic                              out_writes_rd,
  output logic [DATA_WIDTH-1:0]             out_reg1_scalar,
  output logic [DATA_WIDTH-1:0]             out_reg2_scalar,
  output logic [VECTOR_SIZE*ELEM_WIDTH-1:0] out_reg1_vector,
  output logic [VECTOR_SIZE*ELEM_WIDTH-1:0] out_reg2_vector,
  output logic [DATA_WIDTH-1:0]             out_immediate
);

  localparam int VW = VECTOR_SIZE * ELEM_WIDTH;

  logic [OPCODE_WIDTH-1:0]  dec_opcode;
  logic [ADDRESS_WIDTH-1:0] dec_rd, dec_rs1, dec_rs2;
  logic [IMM_WIDTH-1:0]     dec_imm;
  logic                     dec_is_vector, dec_writes;

  assign dec_opcode    = instruction[OPC_LSB +: OPCODE_WIDTH];
  assign dec_rd        = instruction[RD_LSB  +: ADDRESS_WIDTH];
  assign dec_rs1       = instruction[RS1_LSB +: ADDRESS_WIDTH];
  assign dec_rs2       = instruction[RS2_LSB +: ADDRESS_WIDTH];
  assign dec_imm       = instruction[IMM_LSB +: IMM_WIDTH];
  assign dec_is_vector = dec_opcode[OPCODE_WIDTH-1];
  assign dec_writes    = writes_dest(dec_opcode);

  logic [DATA_WIDTH-1:0] s_rdata1, s_rdata2;
  logic [VW-1:0]         v_rdata1, v_rdata2;

  register_file_bypass #(
    .WIDTH(DATA_WIDTH), .DEPTH(SCALAR_REGNUM), .ADDR_WIDTH(ADDRESS_WIDTH)
  ) u_scalar_rf (
    .clock(clock), .reset(reset),
    .we(wb_scalar_en), .waddr(wb_address), .wdata(wb_scalar_data),
    .raddr1(dec_rs1), .raddr2(dec_rs2), .rdata1(s_rdata1), .rdata2(s_rdata2)
  );

  register_file_bypass #(
    .WIDTH(VW), .DEPTH(VECTOR_REGNUM), .ADDR_WIDTH(ADDRESS_WIDTH)
  ) u_vector_rf (
    .clock(clock), .reset(reset),
    .we(wb_vector_en), .waddr(wb_address), .wdata(wb_vector_data),
    .raddr1(dec_rs1), .raddr2(dec_rs2), .rdata1(v_rdata1), .rdata2(v_rdata2)
  );

  logic [SCALAR_REGNUM-1:0] sb_scalar_q, sb_scalar_d;
  logic [VECTOR_REGNUM-1:0] sb_vector_q, sb_vector_d;
  decoded_t                 idex_q, idex_d;
  logic                     out_valid_q, out_valid_d;
  logic                     rs1_busy, rs2_busy, hazard, accept;

  // A pending source whose write-back lands this cycle is satisfied by the bypass.
  always_comb begin
    if (dec_is_vector) begin
      rs1_busy = sb_vector_q[dec_rs1] && !(wb_vector_en && (wb_address == dec_rs1));
      rs2_busy = sb_vector_q[dec_rs2] && !(wb_vector_en && (wb_address == dec_rs2));
    end else begin
      rs1_busy = sb_scalar_q[dec_rs1] && !(wb_scalar_en && (wb_address == dec_rs1));
      rs2_busy = sb_scalar_q[dec_rs2] && !(wb_scalar_en && (wb_address == dec_rs2));
    end
    hazard = rs1_busy || rs2_busy;
  end

  assign in_ready = !hazard && (!out_valid_q || out_ready) && !flush;
  assign accept   = in_valid && in_ready;

  // Clears are applied before the set so a same-cycle set wins.
  always_comb begin
    sb_scalar_d = sb_scalar_q;
    sb_vector_d = sb_vector_q;
    if (wb_scalar_en) sb_scalar_d[wb_address] = 1'b0;
    if (wb_vector_en) sb_vector_d[wb_address] = 1'b0;
    if (flush && out_valid_q && idex_q.writes_rd) begin
      if (idex_q.is_vector) sb_vector_d[idex_q.rd] = 1'b0;
      else                  sb_scalar_d[idex_q.rd] = 1'b0;
    end
    if (accept && dec_writes) begin
      if (dec_is_vector) sb_vector_d[dec_rd] = 1'b1;
      else               sb_scalar_d[dec_rd] = 1'b1;
    end
  end

  always_comb begin
    idex_d      = idex_q;
    out_valid_d = out_valid_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d           = 1'b1;
      idex_d.opcode         = dec_opcode;
      idex_d.rd             = dec_rd;
      idex_d.rs1            = dec_rs1;
      idex_d.rs2            = dec_rs2;
      idex_d.is_vector      = dec_is_vector;
      idex_d.writes_rd      = dec_writes;
      idex_d.reg1_scalar    = s_rdata1;
      idex_d.reg2_scalar    = s_rdata2;
      idex_d.reg1_vector    = v_rdata1;
      idex_d.reg2_vector    = v_rdata2;
      idex_d.immediate      = {{(DATA_WIDTH-IMM_WIDTH){dec_imm[IMM_WIDTH-1]}}, dec_imm};
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sb_scalar_q <= '0;
      sb_vector_q <= '0;
      idex_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      sb_scalar_q <= sb_scalar_d;
      sb_vector_q <= sb_vector_d;
      idex_q      <= idex_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid       = out_valid_q;
  assign out_opcode      = idex_q.opcode;
  assign out_rd          = idex_q.rd;
  assign out_rs1         = idex_q.rs1;
  assign out_rs2         = idex_q.rs2;
  assign out_is_vector   = idex_q.is_vector;
  assign out_writes_rd   = idex_q.writes_rd;
  assign out_reg1_scalar = idex_q.reg1_scalar;
  assign out_reg2_scalar = idex_q.reg2_scalar;
  assign out_reg1_vector = idex_q.reg1_vector;
  assign out_reg2_vector = idex_q.reg2_vector;
  assign out_immediate   = idex_q.immediate;

endmodule
